hex_seg_driver: RTL and testbench

HEX_SEG_DRIVER -- requirements
Module: hex_seg_driver

---
 rtl/hex_seg_driver.sv | 113 +++++++++++
 tb/tb_hex_seg_driver.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hex_seg_driver.sv
// Single-digit 7-segment driver: registered pattern, blink, PWM brightness.
// Optional flash-hold on pattern change is built only when HEX_SEG_FLASH_EN is defined.
module hex_seg_driver #(
  parameter int unsigned BLINK_DIV    = 12500000,
  parameter int unsigned PWM_BITS     = 4,
  parameter int unsigned FLASH_CYCLES = 25000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic                blink_en,
  input  logic [PWM_BITS-1:0] duty,
  output logic [6:0]          hex_n,
  output logic                flashing
);

  localparam int unsigned BlinkW = $clog2(BLINK_DIV);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PwmMax = {PWM_BITS{1'b1}};

  if (BLINK_DIV < 2 || PWM_BITS < 2 || FLASH_CYCLES < 1) begin : g_bad_param
    $error("hex_seg_driver: parameter out of range");
  end

  logic [6:0]          r_seg;
  logic [6:0]          r_hex_n;
  logic [BlinkW-1:0]   r_blink_cnt;
  logic                r_phase;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic                w_pwm_on;
  logic                w_lit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= 7'h00;
    end else begin
      r_seg <= seg_in;
    end
  end

  // Blink: idle holds the on-phase so a blink_en rise starts a full on half-period.
  always_ff @(posedge clk) begin
    if (reset || !blink_en) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == BlinkMax) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Duty is only taken at the end of a PWM period so no period is cut short.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == PwmMax) begin
        r_duty <= duty;
      end
    end
  end

  assign w_pwm_on = (r_pwm_cnt < r_duty) || (r_duty == PwmMax);

`ifdef HEX_SEG_FLASH_EN
  localparam int unsigned FlashW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_CYCLES - 1);

  logic              r_flashing;
  logic [FlashW-1:0] r_flash_cnt;
  logic              w_seg_change;

  assign w_seg_change = (seg_in != r_seg);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flashing  <= 1'b0;
      r_flash_cnt <= '0;
    end else if (w_seg_change) begin
      r_flashing  <= 1'b1;
      r_flash_cnt <= FlashLoad;
    end else if (r_flashing) begin
      if (r_flash_cnt == '0) begin
        r_flashing <= 1'b0;
      end else begin
        r_flash_cnt <= r_flash_cnt - 1'b1;
      end
    end
  end

  assign w_lit    = r_flashing || (w_pwm_on && r_phase);
  assign flashing = r_flashing;
`else
  assign w_lit    = w_pwm_on && r_phase;
  assign flashing = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hex_n <= 7'h7F;
    end else begin
      r_hex_n <= ~(r_seg & {7{w_lit}});
    end
  end

  assign hex_n = r_hex_n;

endmodule

// File: tb/tb_hex_seg_driver.sv
// Directed bench for hex_seg_driver with BLINK_DIV=4, PWM_BITS=2, FLASH_CYCLES=3.
// Build with +define+HEX_SEG_FLASH_EN to exercise the flash-hold variant.
module tb_hex_seg_driver;

  typedef struct {
    logic       rst;
    logic [6:0] seg;
    logic       blink;
    logic [1:0] duty;
    logic [6:0] exp_hex;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       blink_en;
  logic [1:0] duty;
  logic [6:0] hex_n;
  logic       flashing;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  hex_seg_driver #(
    .BLINK_DIV   (4),
    .PWM_BITS    (2),
    .FLASH_CYCLES(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .seg_in  (seg_in),
    .blink_en(blink_en),
    .duty    (duty),
    .hex_n   (hex_n),
    .flashing(flashing)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [6:0] s, input logic b,
                              input logic [1:0] d, input logic [6:0] h, input int rep);
    vec_t v;
    v.rst = r; v.seg = s; v.blink = b; v.duty = d; v.exp_hex = h;
    for (int i = 0; i < rep; i++) tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [6:0] act,
                     input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle just after it.
  task automatic step(input logic r, input logic [6:0] s, input logic b, input logic [1:0] d);
    reset = r; seg_in = s; blink_en = b; duty = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] exp_h[6];
    logic       exp_f[6];
    logic       exp_f_mid;

    reset = 1'b1; seg_in = 7'h00; blink_en = 1'b0; duty = 2'd0;

`ifndef HEX_SEG_FLASH_EN
    // Reset, then dark until duty loads at pwm_cnt wrap.
    add(1'b1, 7'h3F, 1'b0, 2'd3, 7'h7F, 2);
    add(1'b0, 7'h3F, 1'b0, 2'd3, 7'h7F, 4);
    add(1'b0, 7'h3F, 1'b0, 2'd3, 7'h40, 4);
    // duty=1 gives 1/4; duty=2 applied mid-period takes effect after next wrap.
    add(1'b0, 7'h7F, 1'b0, 2'd1, 7'h40, 1);
    add(1'b0, 7'h7F, 1'b0, 2'd1, 7'h00, 4);
    add(1'b0, 7'h7F, 1'b0, 2'd1, 7'h7F, 3);
    add(1'b0, 7'h7F, 1'b0, 2'd1, 7'h00, 1);
    add(1'b0, 7'h7F, 1'b0, 2'd2, 7'h7F, 3);
    add(1'b0, 7'h7F, 1'b0, 2'd2, 7'h00, 2);
    add(1'b0, 7'h7F, 1'b0, 2'd2, 7'h7F, 2);
    // Back to full brightness, then blink 4 on / 4 off, then blink_en falls.
    add(1'b0, 7'h06, 1'b0, 2'd3, 7'h00, 1);
    add(1'b0, 7'h06, 1'b0, 2'd3, 7'h79, 1);
    add(1'b0, 7'h06, 1'b0, 2'd3, 7'h7F, 2);
    add(1'b0, 7'h06, 1'b0, 2'd3, 7'h79, 1);
    add(1'b0, 7'h06, 1'b1, 2'd3, 7'h79, 4);
    add(1'b0, 7'h06, 1'b1, 2'd3, 7'h7F, 4);
    add(1'b0, 7'h06, 1'b1, 2'd3, 7'h79, 4);
    add(1'b0, 7'h06, 1'b1, 2'd3, 7'h7F, 1);
    add(1'b0, 7'h06, 1'b0, 2'd3, 7'h7F, 1);
    add(1'b0, 7'h06, 1'b0, 2'd3, 7'h79, 1);
    // Pattern change: two-cycle latency.
    add(1'b0, 7'h5B, 1'b0, 2'd3, 7'h79, 1);
    add(1'b0, 7'h5B, 1'b0, 2'd3, 7'h24, 2);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].seg, tbl[i].blink, tbl[i].duty);
      chk("tbl_hex_n", i, hex_n, tbl[i].exp_hex);
      chk("tbl_flashing", i, {6'd0, flashing}, 7'd0);
    end
`endif

    // Single pattern change with duty=0.
`ifdef HEX_SEG_FLASH_EN
    exp_h = '{7'h7F, 7'h24, 7'h24, 7'h24, 7'h7F, 7'h7F};
    exp_f = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_f_mid = 1'b1;
`else
    exp_h = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    exp_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_f_mid = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 7'h00, 1'b0, 2'd0);
      chk("rst_hex_n", i, hex_n, 7'h7F);
      chk("rst_flashing", i, {6'd0, flashing}, 7'd0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 7'h00, 1'b0, 2'd0);
      chk("idle_hex_n", i, hex_n, 7'h7F);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 7'h5B, 1'b0, 2'd0);
      chk("flash_hex_n", i, hex_n, exp_h[i]);
      chk("flash_flashing", i, {6'd0, flashing}, {6'd0, exp_f[i]});
    end

    // Reset landing in the blink off-phase and during a flash.
    for (int i = 0; i < 4; i++) step(1'b0, 7'h5B, 1'b1, 2'd3);
    chk("pre_rst_phase", 0, {6'd0, dut.r_phase}, 7'd0);
    step(1'b0, 7'h06, 1'b1, 2'd3);
    chk("pre_rst_flashing", 0, {6'd0, flashing}, {6'd0, exp_f_mid});
    step(1'b1, 7'h06, 1'b1, 2'd3);
    chk("mid_rst_hex_n", 0, hex_n, 7'h7F);
    chk("mid_rst_flashing", 0, {6'd0, flashing}, 7'd0);
    chk("mid_rst_phase", 0, {6'd0, dut.r_phase}, 7'd1);
    chk("mid_rst_blink_cnt", 0, {5'd0, dut.r_blink_cnt}, 7'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
